max1270_axil_csr: RTL and testbench

MAX1270_AXIL_CSR -- requirements
Module: max1270_axil_csr

---
 rtl/max1270_pkg.sv | 32 +++
 rtl/max1270_axil_csr_if.sv | 36 +++
 rtl/max1270_ch_capture.sv | 41 ++++
 rtl/max1270_axil_csr.sv | 202 ++++++++++++++++++++
 tb/tb_max1270_axil_csr.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max1270_pkg.sv
// Shared constants for the MAX1270 AXI-Lite control/status block:
// register offsets, ID magic, AXI response codes and CTRL bit positions.
package max1270_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_CH_EN  = 8'h04;
  localparam logic [7:0] OFF_CH_BIP = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_ID     = 8'h10;
  localparam logic [7:0] OFF_DATA   = 8'h20;

  localparam logic [15:0] ID_MAGIC = 16'h4D12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_START    = 1;
  localparam int CTRL_FREEZE   = 2;
  localparam int CTRL_SIGN_EXT = 3;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_CH_EN,
    SEL_CH_BIP,
    SEL_STATUS,
    SEL_ID,
    SEL_DATA,
    SEL_NONE
  } reg_sel_e;

endpackage

// File: rtl/max1270_axil_csr_if.sv
// AXI-Lite bus (32-bit data, 4-bit strobe) between a master and the MAX1270 CSR slave.
interface max1270_axil_csr_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/max1270_ch_capture.sv
// One ADC channel: sample holding register with NEW / OVERRUN flags.
// A capture beats a same-cycle clear of NEW; OVERRUN looks at NEW before any clear.
module max1270_ch_capture #(
  parameter int SAMPLE_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cap_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    clr_new_i,
  input  logic                    clr_ovr_i,
  output logic [SAMPLE_WIDTH-1:0] sample_o,
  output logic                    new_o,
  output logic                    ovr_o
);
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic                    new_q, new_d;
  logic                    ovr_q, ovr_d;

  always_comb begin
    hold_d = cap_i ? sample_i : hold_q;
    new_d  = cap_i | (new_q & ~clr_new_i);
    ovr_d  = (ovr_q & ~clr_ovr_i) | (cap_i & new_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      new_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      new_q  <= new_d;
      ovr_q  <= ovr_d;
    end
  end

  assign sample_o = hold_q;
  assign new_o    = new_q;
  assign ovr_o    = ovr_q;
endmodule

// File: rtl/max1270_axil_csr.sv
// AXI-Lite control/status registers for a MAX1270-style multi-channel ADC front end:
// run/start/freeze control, channel enables, per-channel sample capture and W1C status.
module max1270_axil_csr
  import max1270_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_CH       = 8,
  parameter int SAMPLE_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  max1270_axil_csr_if.slave              s_axil,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] i_sample_data,
  input  logic [NUM_CH-1:0]              i_sample_valid,
  output logic                           o_run,
  output logic                           o_start,
  output logic [NUM_CH-1:0]              o_ch_enable,
  output logic [NUM_CH-1:0]              o_ch_bipolar
);
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              run_q, run_d, freeze_q, freeze_d, sext_q, sext_d, start_q, start_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d, ch_bip_q, ch_bip_d;

  logic              wr_acc, rd_acc;
  reg_sel_e          wr_sel, rd_sel;
  logic [31:0]       wmask, rd_data;
  logic [1:0]        rd_resp;
  logic [NUM_CH-1:0] cap, clr_new, clr_ovr, new_vec, ovr_vec;
  logic [NUM_CH*16-1:0] ext_flat;

  function automatic logic [ADDR_WIDTH-3:0] word_of(input logic [7:0] off);
    return (ADDR_WIDTH-2)'(off >> 2);
  endfunction

  // Decode on word address; byte lanes within a word are selected by wstrb.
  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-3:0] w;
    w = a[ADDR_WIDTH-1:2];
    if (w == word_of(OFF_CTRL))   return SEL_CTRL;
    if (w == word_of(OFF_CH_EN))  return SEL_CH_EN;
    if (w == word_of(OFF_CH_BIP)) return SEL_CH_BIP;
    if (w == word_of(OFF_STATUS)) return SEL_STATUS;
    if (w == word_of(OFF_ID))     return SEL_ID;
    if (w >= word_of(OFF_DATA) && w < word_of(OFF_DATA) + (ADDR_WIDTH-2)'(NUM_CH/2))
      return SEL_DATA;
    return SEL_NONE;
  endfunction

  function automatic logic [15:0] ext16(input logic [SAMPLE_WIDTH-1:0] s, input logic sx);
    logic signed [SAMPLE_WIDTH-1:0] ss;
    ss = $signed(s);
    return sx ? 16'(ss) : 16'(s);
  endfunction

  assign wr_acc = s_axil.awvalid & s_axil.wvalid & (~bvalid_q | s_axil.bready) &
                  ~awready_q & ~wready_q;
  assign rd_acc = s_axil.arvalid & (~rvalid_q | s_axil.rready) & ~arready_q;
  assign cap    = i_sample_valid & ch_en_q & {NUM_CH{~freeze_q}};
  assign wmask  = {{8{s_axil.wstrb[3]}}, {8{s_axil.wstrb[2]}},
                   {8{s_axil.wstrb[1]}}, {8{s_axil.wstrb[0]}}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SAMPLE_WIDTH-1:0] smp;
    max1270_ch_capture #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_cap (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap_i     (cap[c]),
      .sample_i  (i_sample_data[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .clr_new_i (clr_new[c]),
      .clr_ovr_i (clr_ovr[c]),
      .sample_o  (smp),
      .new_o     (new_vec[c]),
      .ovr_o     (ovr_vec[c])
    );
    assign ext_flat[c*16 +: 16] = ext16(smp, sext_q);
  end

  // Read mux sees only current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_sel  = decode(s_axil.araddr);
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_CTRL: begin
        rd_data[CTRL_RUN]      = run_q;
        rd_data[CTRL_FREEZE]   = freeze_q;
        rd_data[CTRL_SIGN_EXT] = sext_q;
      end
      SEL_CH_EN:  rd_data = 32'(ch_en_q);
      SEL_CH_BIP: rd_data = 32'(ch_bip_q);
      SEL_STATUS: rd_data = {16'(ovr_vec), 16'(new_vec)};
      SEL_ID:     rd_data = {ID_MAGIC, 8'(NUM_CH), 8'(SAMPLE_WIDTH)};
      SEL_DATA: begin
        for (int k = 0; k < NUM_CH/2; k++)
          if (s_axil.araddr[ADDR_WIDTH-1:2] == word_of(OFF_DATA) + (ADDR_WIDTH-2)'(k))
            rd_data = {ext_flat[(2*k)*16 +: 16], ext_flat[(2*k+1)*16 +: 16]};
      end
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    wr_sel    = decode(s_axil.awaddr);
    awready_d = wr_acc;
    wready_d  = wr_acc;
    arready_d = rd_acc;
    bvalid_d  = bvalid_q & ~s_axil.bready;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q & ~s_axil.rready;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    run_d     = run_q;
    freeze_d  = freeze_q;
    sext_d    = sext_q;
    start_d   = 1'b0;
    ch_en_d   = ch_en_q;
    ch_bip_d  = ch_bip_q;
    clr_new   = '0;
    clr_ovr   = '0;
    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (wr_sel)
        SEL_CTRL: if (s_axil.wstrb[0]) begin
          run_d    = s_axil.wdata[CTRL_RUN];
          start_d  = s_axil.wdata[CTRL_START];
          freeze_d = s_axil.wdata[CTRL_FREEZE];
          sext_d   = s_axil.wdata[CTRL_SIGN_EXT];
        end
        SEL_CH_EN:  ch_en_d  = (ch_en_q & ~wmask[NUM_CH-1:0]) |
                               (s_axil.wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
        SEL_CH_BIP: ch_bip_d = (ch_bip_q & ~wmask[NUM_CH-1:0]) |
                               (s_axil.wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
        SEL_STATUS: begin
          clr_new = s_axil.wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0];
          clr_ovr = s_axil.wdata[16 +: NUM_CH] & wmask[16 +: NUM_CH];
        end
        default: bresp_d = RESP_SLVERR;
      endcase
    end
    if (rd_acc) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      run_q     <= 1'b0;
      freeze_q  <= 1'b0;
      sext_q    <= 1'b0;
      start_q   <= 1'b0;
      ch_en_q   <= '0;
      ch_bip_q  <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      run_q     <= run_d;
      freeze_q  <= freeze_d;
      sext_q    <= sext_d;
      start_q   <= start_d;
      ch_en_q   <= ch_en_d;
      ch_bip_q  <= ch_bip_d;
    end
  end

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign o_run          = run_q;
  assign o_start        = start_q;
  assign o_ch_enable    = ch_en_q;
  assign o_ch_bipolar   = ch_bip_q;

  // Protection bits and bus bits outside the implemented fields carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.wdata, wmask,
                       s_axil.awaddr[1:0], s_axil.araddr[1:0]};
endmodule

// File: tb/tb_max1270_axil_csr.sv
// Bench for max1270_axil_csr: directed scenarios plus random traffic against a register-level model.
module tb_max1270_axil_csr;
  localparam int AW  = 16;
  localparam int NCH = 8;
  localparam int SW  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [NCH*SW-1:0] sdata;
  logic [NCH-1:0]    svalid;
  logic              run, start;
  logic [NCH-1:0]    chen, chbip;

  max1270_axil_csr_if #(.ADDR_WIDTH(AW)) bus ();

  max1270_axil_csr #(.ADDR_WIDTH(AW), .NUM_CH(NCH), .SAMPLE_WIDTH(SW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axil         (bus),
    .i_sample_data  (sdata),
    .i_sample_valid (svalid),
    .o_run          (run),
    .o_start        (start),
    .o_ch_enable    (chen),
    .o_ch_bipolar   (chbip)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic           m_run, m_frz, m_sx;
  logic [NCH-1:0] m_en, m_bip, m_new, m_ovr;
  int             m_hold[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_frz = 0; m_sx = 0;
    m_en = '0; m_bip = '0; m_new = '0; m_ovr = '0;
    for (int c = 0; c < NCH; c++) m_hold[c] = 0;
  endtask

  function automatic logic [15:0] m_ext(input int v);
    if (m_sx && v >= (1 << (SW-1))) return 16'(v + 65536 - (1 << SW));
    return 16'(v);
  endfunction

  task automatic m_read(input int addr, output logic [31:0] d, output logic [1:0] r);
    int k;
    d = '0; r = 2'b00;
    if (addr == 0) begin
      d[0] = m_run; d[2] = m_frz; d[3] = m_sx;
    end else if (addr == 4)  d[NCH-1:0] = m_en;
    else if (addr == 8)      d[NCH-1:0] = m_bip;
    else if (addr == 12) begin
      for (int c = 0; c < NCH; c++) begin
        d[c] = m_new[c]; d[16+c] = m_ovr[c];
      end
    end else if (addr == 16) d = {16'h4D12, 8'(NCH), 8'(SW)};
    else if (addr >= 32 && addr < 32 + 2*NCH) begin
      k = (addr - 32) / 4;
      d = {m_ext(m_hold[2*k]), m_ext(m_hold[2*k+1])};
    end else r = 2'b10;
  endtask

  // One accepted cycle: optional write plus sample strobes, using pre-cycle state for capture gating.
  task automatic m_apply(input int addr, input logic [31:0] d, input logic [3:0] s, input logic do_wr,
                         input logic [NCH-1:0] vm, input logic [NCH*SW-1:0] vd,
                         output logic [1:0] resp, output logic exp_start);
    logic [NCH-1:0] capm, cn, co;
    logic           nw_pre;
    capm = vm & m_en & {NCH{~m_frz}};
    cn = '0; co = '0; resp = 2'b00; exp_start = 1'b0;
    if (do_wr) begin
      case (addr)
        0: if (s[0]) begin m_run = d[0]; exp_start = d[1]; m_frz = d[2]; m_sx = d[3]; end
        4: for (int b = 0; b < NCH; b++) if (s[b/8]) m_en[b] = d[b];
        8: for (int b = 0; b < NCH; b++) if (s[b/8]) m_bip[b] = d[b];
        12: for (int b = 0; b < NCH; b++) begin
              if (s[b/8])       cn[b] = d[b];
              if (s[(16+b)/8])  co[b] = d[16+b];
            end
        default: resp = 2'b10;
      endcase
    end
    for (int c = 0; c < NCH; c++) begin
      nw_pre = m_new[c];
      if (capm[c]) begin
        m_hold[c] = int'(vd[c*SW +: SW]);
        m_new[c]  = 1'b1;
        m_ovr[c]  = (m_ovr[c] & ~co[c]) | nw_pre;
      end else begin
        m_new[c] = m_new[c] & ~cn[c];
        m_ovr[c] = m_ovr[c] & ~co[c];
      end
    end
  endtask

  task automatic chk_mirrors();
    chk("o_run", 32'(run), 32'(m_run));
    chk("o_ch_enable", 32'(chen), 32'(m_en));
    chk("o_ch_bipolar", 32'(chbip), 32'(m_bip));
  endtask

  task automatic axw(input int addr, input logic [31:0] d, input logic [3:0] s,
                     input logic [NCH-1:0] vm, input logic [NCH*SW-1:0] vd);
    logic [1:0] er;
    logic       es;
    int         n;
    @(negedge clk);
    bus.awaddr = AW'(addr); bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    sdata = vd; svalid = vm;
    @(posedge clk); #1;
    svalid = '0;
    m_apply(addr, d, s, 1'b1, vm, vd, er, es);
    n = 0;
    while (!bus.awready && n < 10) begin @(posedge clk); #1; n++; end
    chk("awready", 32'(bus.awready), 32'd1);
    chk("wready", 32'(bus.wready), 32'd1);
    chk("bvalid", 32'(bus.bvalid), 32'd1);
    chk($sformatf("bresp@%0h", addr), 32'(bus.bresp), 32'(er));
    chk("o_start", 32'(start), 32'(es));
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("awready_pulse", 32'(bus.awready), 32'd0);
    chk("bvalid_done", 32'(bus.bvalid), 32'd0);
    chk("o_start_end", 32'(start), 32'd0);
    chk_mirrors();
  endtask

  task automatic axr(input int addr, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    bus.araddr = AW'(addr); bus.arvalid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!bus.arready && n < 10) begin @(posedge clk); #1; n++; end
    chk("arready", 32'(bus.arready), 32'd1);
    chk("rvalid", 32'(bus.rvalid), 32'd1);
    d = bus.rdata; r = bus.rresp;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    chk("rvalid_done", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic axr_model(input int addr);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    axr(addr, d, r);
    m_read(addr, ed, er);
    chk($sformatf("rdata@%0h", addr), d, ed);
    chk($sformatf("rresp@%0h", addr), 32'(r), 32'(er));
  endtask

  task automatic pulse(input logic [NCH-1:0] vm, input logic [NCH*SW-1:0] vd);
    logic [1:0] er;
    logic       es;
    @(negedge clk);
    sdata = vd; svalid = vm;
    @(posedge clk); #1;
    svalid = '0;
    m_apply(0, 32'd0, 4'd0, 1'b0, vm, vd, er, es);
  endtask

  function automatic logic [NCH*SW-1:0] ch_val(input int c, input int v);
    logic [NCH*SW-1:0] x;
    x = '0;
    x[c*SW +: SW] = SW'(v);
    return x;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int addrs[16] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 48, 64, 128, 256};

  initial begin
    logic [31:0] d, old;
    logic [1:0]  r, er;
    logic        es;
    int          op, a;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 1; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0;
    bus.rready = 1; sdata = '0; svalid = '0;
    m_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_o_start", 32'(start), 32'd0);
    chk_mirrors();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ID and CTRL after reset
    axr(16, d, r);
    chk("id", d, 32'h4D12080C);
    chk("id_resp", 32'(r), 32'd0);
    axr(0, d, r);
    chk("ctrl_reset", d, 32'd0);

    // Sign-extended capture
    axw(4, 32'hFF, 4'hF, '0, '0);
    axw(0, 32'h8, 4'h1, '0, '0);
    pulse(8'h03, ch_val(0, 12'h800) | ch_val(1, 12'h7FF));
    axr(32, d, r);
    chk("data0_sext", d, 32'hF80007FF);
    axr(12, d, r);
    chk("status_new", d, 32'h00000003);

    // Overrun, then W1C racing a capture
    pulse(8'h01, ch_val(0, 12'h123));
    axr(12, d, r);
    chk("status_ovr", d, 32'h00010003);
    axw(12, 32'h00010001, 4'hF, 8'h01, ch_val(0, 12'h456));
    axr(12, d, r);
    chk("status_w1c_race", d, 32'h00010003);
    axw(12, 32'h00030003, 4'hF, '0, '0);
    axr(12, d, r);
    chk("status_w1c", d, 32'h00000000);

    // Freeze blocks capture; illegal accesses
    axw(0, 32'hC, 4'h1, '0, '0);
    axr(36, old, r);
    pulse(8'h04, ch_val(2, 12'h123));
    axr(36, d, r);
    chk("freeze_data", d, old);
    axr(12, d, r);
    chk("freeze_new2", 32'(d[2]), 32'd0);
    axw(32, 32'hDEADBEEF, 4'hF, '0, '0);
    axr(64, d, r);
    chk("unmapped_rresp", 32'(r), 32'd2);
    chk("unmapped_rdata", d, 32'd0);

    // Start pulse, CTRL reads back without START
    axw(0, 32'h2, 4'h1, '0, '0);
    axr(0, d, r);
    chk("ctrl_after_start", d, 32'd0);

    // bready held low: bvalid persists, no second accept
    @(negedge clk);
    bus.bready = 1'b0;
    bus.awaddr = AW'(8); bus.wdata = 32'h5A; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    m_apply(8, 32'h5A, 4'hF, 1'b1, '0, '0, er, es);
    chk("bp_awready", 32'(bus.awready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_bvalid_held", 32'(bus.bvalid), 32'd1);
      chk("bp_no_awready", 32'(bus.awready), 32'd0);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(posedge clk); #1;
    chk("bp_bvalid_drop", 32'(bus.bvalid), 32'd0);
    chk_mirrors();

    // Read and write of the same register in one cycle: read sees old value
    @(negedge clk);
    bus.araddr = AW'(8); bus.arvalid = 1'b1;
    bus.awaddr = AW'(8); bus.wdata = 32'hA5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    old = 32'(m_bip);
    @(posedge clk); #1;
    m_apply(8, 32'hA5, 4'hF, 1'b1, '0, '0, er, es);
    chk("rw_arready", 32'(bus.arready), 32'd1);
    chk("rw_awready", 32'(bus.awready), 32'd1);
    chk("rw_old_value", bus.rdata, old);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    axr_model(8);

    // Reset in the middle of a write response
    axw(0, 32'h1, 4'h1, '0, '0);
    @(negedge clk);
    bus.bready = 1'b0;
    bus.awaddr = AW'(4); bus.wdata = 32'h0F; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    m_reset();
    #1;
    chk("midrst_bvalid", 32'(bus.bvalid), 32'd0);
    chk_mirrors();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; bus.bready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_resp", 32'(bus.bvalid), 32'd0);
    axr_model(12);
    axr_model(32);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      a  = addrs[$urandom_range(0, 15)];
      if (op < 3) begin
        pulse(NCH'($urandom_range(0, (1 << NCH) - 1)), {$urandom(), $urandom(), $urandom()});
      end else if (op < 6) begin
        axw(a, $urandom(), 4'($urandom_range(0, 15)),
            (op == 5) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0,
            {$urandom(), $urandom(), $urandom()});
      end else begin
        axr_model(a);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
